n1_prog_loader: RTL and testbench

Upstream program-load stage for the n1 CPU core. Accepts a framed byte stream on an 8-bit bus, assembles big-endian 16-bit instruction words, and writes them sequentially into the core's program RAM through a write-port handshake. Frame layout is: length byte, then 2×N data bytes, then an XOR checksum byte. Drives done/error status so the core is released from reset only after a verified load.

---
 rtl/n1_pkg.sv | 21 ++
 rtl/n1_prog_loader.sv | 144 ++++++++++++++
 tb/tb_n1_prog_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/n1_pkg.sv
// Shared definitions for the n1 core and its program loader.
package n1_pkg;

  localparam int RAM_WORDS_DEF = 127;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WR,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/n1_prog_loader.sv
// Framed byte-stream loader: length, big-endian word pairs, XOR checksum,
// written sequentially into the n1 program RAM.
module n1_prog_loader
  import n1_pkg::*;
#(
  parameter int RAM_WORDS = RAM_WORDS_DEF,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [15:0]       mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   WORD_ONE = 1;

  loader_state_e     state_reg, state_next;
  logic [7:0]        count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        csum_reg;
  logic [7:0]        hi_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [15:0]       wr_data_reg;
  logic [1:0]        err_code_reg;
  logic [ADDR_W:0]   words_loaded_reg;

  logic accept;
  logic len_bad;
  logic last_word;

  assign accept    = byte_valid & byte_ready;
  assign len_bad   = (byte_in == 8'd0) || ({24'd0, byte_in} > RAM_WORDS);
  assign last_word = ({{(31-ADDR_W){1'b0}}, words_loaded_reg} + 32'd1) == {24'd0, count_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE, ERR: if (start) state_next = LEN;
        LEN:  if (accept) state_next = len_bad ? ERR : HI;
        HI:   if (accept) state_next = LO;
        LO:   if (accept) state_next = WR;
        WR:   if (mem_wr_ready) state_next = last_word ? CSUM : HI;
        CSUM: if (accept) state_next = (byte_in == csum_reg) ? DONE : ERR;
        default: state_next = IDLE;
      endcase
    end
  end

  // Every status output is a pure decode of the state register.
  always_comb begin
    byte_ready = 1'b0;
    mem_wr_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state_reg)
      LEN, HI, LO, CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WR: begin
        mem_wr_en = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done  = 1'b1;
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg        <= '0;
      addr_reg         <= '0;
      csum_reg         <= '0;
      hi_reg           <= '0;
      wr_addr_reg      <= '0;
      wr_data_reg      <= '0;
      err_code_reg     <= ERR_NONE;
      words_loaded_reg <= '0;
    end else if (abort) begin
      err_code_reg <= ERR_NONE;
    end else begin
      case (state_reg)
        LEN: if (accept) begin
          if (len_bad) begin
            err_code_reg <= ERR_LEN;
          end else begin
            count_reg        <= byte_in;
            addr_reg         <= '0;
            csum_reg         <= '0;
            words_loaded_reg <= '0;
          end
        end
        HI: if (accept) begin
          hi_reg   <= byte_in;
          csum_reg <= csum_reg ^ byte_in;
        end
        LO: if (accept) begin
          wr_data_reg <= {hi_reg, byte_in};
          wr_addr_reg <= addr_reg;
          csum_reg    <= csum_reg ^ byte_in;
        end
        WR: if (mem_wr_ready) begin
          addr_reg         <= addr_reg + ADDR_ONE;
          words_loaded_reg <= words_loaded_reg + WORD_ONE;
        end
        CSUM: if (accept && byte_in != csum_reg) err_code_reg <= ERR_CSUM;
        DONE, ERR: if (start) begin
          err_code_reg     <= ERR_NONE;
          words_loaded_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_wr_addr  = wr_addr_reg;
  assign mem_wr_data  = wr_data_reg;
  assign err_code     = err_code_reg;
  assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_n1_prog_loader.sv
// Directed bench for n1_prog_loader: framed loads, backpressure, errors,
// abort/reset recovery and a full-size stalled frame.
module tb_n1_prog_loader;

  localparam int RAM_WORDS = 127;
  localparam int ADDR_W    = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [15:0]       mem_wr_data;
  logic              mem_wr_ready = 1'b1;
  logic              busy, done, error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  n1_prog_loader #(.RAM_WORDS(RAM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;
  int wr_en_cycles = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [15:0]       wr_data_q[$];

  // Scoreboard of completed RAM writes as the RAM would see them.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst_n && mem_wr_en) wr_en_cycles <= wr_en_cycles + 1;
    if (rst_n && mem_wr_en && mem_wr_ready && !abort) begin
      wr_addr_q.push_back(mem_wr_addr);
      wr_data_q.push_back(mem_wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Entered and left on a negedge; optional random idle gap before the byte.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps && $urandom_range(0, 1) == 1) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic check_log(input string tag, input int base, input int n,
                           input logic [15:0] d0, input logic [15:0] d1);
    check({tag, "_nwr"}, wr_data_q.size() - base, n);
    if (wr_data_q.size() - base >= 1) begin
      check({tag, "_a0"}, wr_addr_q[base], 0);
      check({tag, "_d0"}, wr_data_q[base], d0);
    end
    if (n > 1 && wr_data_q.size() - base >= 2) begin
      check({tag, "_a1"}, wr_addr_q[base+1], 1);
      check({tag, "_d1"}, wr_data_q[base+1], d1);
    end
  endtask

  initial begin
    int base, t0, en0;
    logic [7:0] cs;

    #2;
    check("rst_busy", busy, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_status", {done, error, err_code}, 0);
    check("rst_addr_data", {mem_wr_addr, mem_wr_data}, 0);
    check("rst_words", words_loaded, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, full throughput
    base = wr_data_q.size();
    pulse_start();
    check("good_ready_len", byte_ready, 1);
    t0 = cycle;
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h03, 0);
    send_byte(8'h70, 0); send_byte(8'h05, 0); send_byte(8'h64, 0);
    check("good_cycles", cycle - t0, 8);
    check("good_status", {done, error, err_code, busy}, 5'b10000);
    check("good_words", words_loaded, 2);
    check_log("good", base, 2, 16'h1203, 16'h7005);

    // Backpressure on the first write
    base = wr_data_q.size();
    mem_wr_ready = 1'b0;
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h03, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i), {mem_wr_en, byte_ready, mem_wr_addr, mem_wr_data},
            {1'b1, 1'b0, 7'd0, 16'h1203});
      @(negedge clk);
    end
    mem_wr_ready = 1'b1;
    send_byte(8'h70, 0); send_byte(8'h05, 0); send_byte(8'h64, 0);
    check("bp_status", {done, error, err_code}, 4'b1000);
    check("bp_words", words_loaded, 2);
    check_log("bp", base, 2, 16'h1203, 16'h7005);

    // Checksum mismatch
    base = wr_data_q.size();
    pulse_start();
    check("restart_clears", {done, words_loaded}, 0);
    send_byte(8'h01, 0); send_byte(8'h80, 0); send_byte(8'h00, 0); send_byte(8'h81, 0);
    check("csum_status", {done, error, err_code}, 4'b0110);
    check("csum_words", words_loaded, 1);
    check_log("csum", base, 1, 16'h8000, 16'h0000);

    // Bad lengths: zero and one past capacity
    en0 = wr_en_cycles;
    pulse_start();
    check("start_clears_err", {error, err_code}, 0);
    send_byte(8'h00, 0);
    check("len0_status", {done, error, err_code}, 4'b0101);
    pulse_start();
    send_byte(8'h80, 0);
    check("len128_status", {done, error, err_code}, 4'b0101);
    check("badlen_no_wr", wr_en_cycles - en0, 0);

    // Abort during the second word
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h03, 0); send_byte(8'h70, 0);
    pulse_abort();
    check("abort_state", {busy, mem_wr_en, byte_ready, done, error, err_code}, 0);
    check("abort_words", words_loaded, 1);
    pulse_start();
    check("start_ignored_busy", busy, 1);
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h03, 0);
    check("pre_rst_wr", mem_wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {busy, mem_wr_en, byte_ready, done, error, err_code}, 0);
    check("rst_async_dp", {mem_wr_addr, mem_wr_data, words_loaded}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_data_q.size();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h03, 0);
    send_byte(8'h70, 0); send_byte(8'h05, 0); send_byte(8'h64, 0);
    check("recover_status", {done, error, err_code}, 4'b1000);
    check_log("recover", base, 2, 16'h1203, 16'h7005);

    // Full-size frame with random input stalls
    base = wr_data_q.size();
    cs = 8'h00;
    pulse_start();
    send_byte(8'd127, 1);
    for (int i = 0; i < 127; i++) begin
      send_byte(8'(i), 1);
      send_byte(~8'(i), 1);
      cs = cs ^ 8'(i) ^ ~8'(i);
    end
    send_byte(cs, 1);
    check("full_status", {done, error, err_code}, 4'b1000);
    check("full_words", words_loaded, 127);
    check("full_nwr", wr_data_q.size() - base, 127);
    if (wr_data_q.size() - base == 127) begin
      for (int i = 0; i < 127; i++) begin
        if (wr_addr_q[base+i] !== 7'(i) || wr_data_q[base+i] !== {8'(i), ~8'(i)}) begin
          check($sformatf("full_w%0d", i), {9'd0, wr_addr_q[base+i], wr_data_q[base+i]},
                {9'd0, 7'(i), 8'(i), ~8'(i)});
        end
      end
      check("full_last", {9'd0, wr_addr_q[base+126], wr_data_q[base+126]},
            {9'd0, 7'd126, 16'h7e81});
    end
    pulse_start();
    check("restart_len", {busy, byte_ready, done}, 3'b110);
    check("restart_words", words_loaded, 0);
    pulse_abort();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
